// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bundle: pipeline requests into the PC sequencer and
// the registered fetch PC/qualifiers coming back out.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

interface fetch_ctrl_if #(
    parameter int PC_W = `PC_WIDTH
);
    logic            stall_i;
    logic            br_valid_i;
    logic [PC_W-1:0] br_target_i;
    logic            trap_valid_i;
    logic [PC_W-1:0] trap_vector_i;
    logic            halt_i;
    logic [PC_W-1:0] pc_o;
    logic            pc_valid_o;
    logic            flush_o;
    logic [1:0]      state_o;

    // Pipeline side: issues requests, observes the fetch PC
    modport master (
        output stall_i, br_valid_i, br_target_i, trap_valid_i, trap_vector_i, halt_i,
        input  pc_o, pc_valid_o, flush_o, state_o
    );

    // Sequencer side
    modport slave (
        input  stall_i, br_valid_i, br_target_i, trap_valid_i, trap_vector_i, halt_i,
        output pc_o, pc_valid_o, flush_o, state_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer: hold / increment / branch / trap redirect with a
// fixed-length flush pulse after every redirect. All outputs registered.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module fetch_ctrl #(
    parameter int              PC_W         = `PC_WIDTH,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [3:0]      CNT_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_ONE     = 1;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            flush_q, flush_d;
    logic [3:0]      cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect target: trap always outranks branch; branches only count in RUN
    logic            redir;
    logic [PC_W-1:0] redir_pc;

    always_comb begin
        redir    = 1'b0;
        redir_pc = bus.trap_vector_i;
        if (bus.trap_valid_i) begin
            redir = 1'b1;
        end else if (state_q == RUN && bus.br_valid_i) begin
            redir    = 1'b1;
            redir_pc = bus.br_target_i;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;

        if (redir && state_q != BOOT) begin
            state_d = FLUSH;
            pc_d    = redir_pc;
            valid_d = 1'b0;
            flush_d = 1'b1;
            cnt_d   = CNT_RELOAD;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    flush_d = 1'b0;
                end
                RUN: begin
                    flush_d = 1'b0;
                    if (bus.halt_i) begin
                        state_d = HALT;
                        valid_d = 1'b0;
                    end else begin
                        valid_d = 1'b1;
                        if (!bus.stall_i) begin
                            pc_d = pc_q + PC_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        valid_d = 1'b0;
                        flush_d = 1'b1;
                    end
                end
                HALT: begin
                    valid_d = 1'b0;
                    flush_d = 1'b0;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = valid_q;
    assign bus.flush_o    = flush_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl (8-bit PC, 2-cycle flush).
module tb_fetch_ctrl;
    localparam int PC_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.PC_W(PC_W)) bus ();

    fetch_ctrl #(
        .PC_W        (PC_W),
        .RESET_PC    (8'h00),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic       stall;
        logic       br;
        logic [7:0] tgt;
        logic       trap;
        logic [7:0] vec;
        logic       halt;
        logic [7:0] pc;
        logic       valid;
        logic       flush;
        logic [1:0] st;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    int applied = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [7:0] pc, input logic valid,
                         input logic flush, input logic [1:0] st);
        applied++;
        if ({bus.pc_o, bus.pc_valid_o, bus.flush_o, bus.state_o} !== {pc, valid, flush, st}) begin
            miscompares++;
            $display("FAIL %s: got pc=%02h valid=%b flush=%b state=%0d, want pc=%02h valid=%b flush=%b state=%0d",
                     name, bus.pc_o, bus.pc_valid_o, bus.flush_o, bus.state_o, pc, valid, flush, st);
        end else begin
            $display("ok   %s: pc=%02h valid=%b flush=%b state=%0d",
                     name, bus.pc_o, bus.pc_valid_o, bus.flush_o, bus.state_o);
        end
    endtask

    task automatic drive(input logic stall, input logic br, input logic [7:0] tgt,
                         input logic trap, input logic [7:0] vec, input logic halt);
        bus.stall_i       = stall;
        bus.br_valid_i    = br;
        bus.br_target_i   = tgt;
        bus.trap_valid_i  = trap;
        bus.trap_vector_i = vec;
        bus.halt_i        = halt;
    endtask

    initial begin
        //            stall br tgt   trap vec   halt  pc    v  f  st
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 2'd1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 2'd1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 2'd1};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 2'd1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b0, 2'd1};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b0, 2'd1};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b0, 2'd1};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h06, 1'b1, 1'b0, 2'd1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 1'b0, 2'd1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h08, 1'b1, 1'b0, 2'd1};
        // branch while stalled: redirect wins
        tbl[11] = '{1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0, 1'b1, 2'd2};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0, 1'b1, 2'd2};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 2'd1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 1'b0, 2'd1};
        // trap+branch together, then trap re-redirect, then branch ignored in FLUSH
        tbl[15] = '{1'b0, 1'b1, 8'h40, 1'b1, 8'h10, 1'b0, 8'h10, 1'b0, 1'b1, 2'd2};
        tbl[16] = '{1'b0, 1'b1, 8'h50, 1'b1, 8'h20, 1'b0, 8'h20, 1'b0, 1'b1, 2'd2};
        tbl[17] = '{1'b0, 1'b1, 8'h60, 1'b0, 8'h00, 1'b0, 8'h20, 1'b0, 1'b1, 2'd2};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h20, 1'b1, 1'b0, 2'd1};
        // PC wrap at all-ones
        tbl[19] = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 2'd2};
        tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 2'd2};
        tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 2'd1};
        tbl[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1};
        // halt (beats stall), branches ignored, trap exits
        tbl[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 2'd3};
        tbl[24] = '{1'b1, 1'b1, 8'h70, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3};
        tbl[25] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 2'd3};
        tbl[26] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 8'h30, 1'b0, 1'b1, 2'd2};
        tbl[27] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h30, 1'b0, 1'b1, 2'd2};
        tbl[28] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h30, 1'b1, 1'b0, 2'd1};
        tbl[29] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h31, 1'b1, 1'b0, 2'd1};

        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("reset", 8'h00, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].trap, tbl[i].vec, tbl[i].halt);
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), tbl[i].pc, tbl[i].valid, tbl[i].flush, tbl[i].st);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a flush
        drive(1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 check("pre_async_flush", 8'h55, 1'b0, 1'b1, 2'd2);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_reset", 8'h00, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1 check("reset_held", 8'h00, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("post_reset_run", 8'h00, 1'b1, 1'b0, 2'd1);
        @(posedge clk);
        #1 check("post_reset_inc", 8'h01, 1'b1, 1'b0, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
